// File: rtl/bar_render_engine.sv
// bar_render_engine: renders NUM_BARS white vertical bars; Y positions are updated through a custom-instruction port
//   Ports: i_clk, i_rst (sync, active-high)
//          i_clk_en, i_start, i_dataa[31:0] -> o_done, o_result[31:0] (command port)
//          i_x, i_y, i_active, i_frame -> o_pixel (pixel path, 1-cycle latency)
//   Optional macro BAR_READBACK_EN: opcodes 10/11 read back active/shadow Y.
module bar_render_engine #(
    parameter int NUM_BARS = 2,
    parameter int BAR_W    = 10,
    parameter int BAR_H    = 80,
    parameter int X_FIRST  = 15,
    parameter int X_STEP   = 270,
    parameter int SCREEN_H = 600
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clk_en,
    input  logic        i_start,
    input  logic [31:0] i_dataa,
    output logic        o_done,
    output logic [31:0] o_result,
    input  logic [9:0]  i_x,
    input  logic [9:0]  i_y,
    input  logic        i_active,
    input  logic        i_frame,
    output logic        o_pixel
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    localparam logic [9:0] Y_MAX  = 10'(SCREEN_H - BAR_H);
    localparam logic [9:0] Y_INIT = 10'((SCREEN_H - BAR_H) / 2);
    state_t state, state_nxt;
    logic [1:0] op;
    logic [3:0] idx;
    logic [9:0] y_cmd, y_clamp;
    logic [9:0] shadow_y [NUM_BARS];
    logic [9:0] active_y [NUM_BARS];
    logic [NUM_BARS-1:0] pending;
    logic idx_ok, do_write, do_commit, hit, accept;
    logic [31:0] res_c, result;
    logic unused_bits;
    assign unused_bits = ^{i_dataa[29:16], i_dataa[11:10]};
    assign accept    = state == IDLE && i_start && i_clk_en;
    assign idx_ok    = int'(idx) < NUM_BARS;
    assign y_clamp   = y_cmd > Y_MAX ? Y_MAX : y_cmd;
    assign do_write  = state == EXEC && idx_ok && op == 2'b00;
    // a frame pulse and a COMMIT do the same thing, so they simply OR together
    assign do_commit = i_frame || (state == EXEC && idx_ok && op == 2'b01);
    assign o_done    = state == DONE;
    assign o_result  = result;
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? EXEC : IDLE;
            EXEC:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (accept) begin
            op    <= i_dataa[31:30];
            idx   <= i_dataa[15:12];
            y_cmd <= i_dataa[9:0];
        end
    end
    always_comb begin
        res_c = idx_ok ? 32'h0 : 32'hFFFF_FFFF;
`ifdef BAR_READBACK_EN
        for (int k = 0; k < NUM_BARS; k++) begin
            if (4'(k) == idx && op == 2'b10) res_c = {22'b0, active_y[k]};
            if (4'(k) == idx && op == 2'b11) res_c = {pending[k], 21'b0, shadow_y[k]};
        end
`endif
    end
    // x bounds are compared as int so bars placed beyond the 11-bit range can never alias
    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < NUM_BARS; k++)
            hit = hit || (int'(i_x) >= X_FIRST + k * X_STEP && int'(i_x) < X_FIRST + k * X_STEP + BAR_W &&
                          11'(i_y) >= 11'(active_y[k]) && 11'(i_y) < 11'(active_y[k]) + 11'(BAR_H));
    end
    // the write is placed after the commit so a coinciding WRITE stays pending with its new value
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < NUM_BARS; k++) begin
                shadow_y[k] <= Y_INIT;
                active_y[k] <= Y_INIT;
            end
            pending <= '0;
            result  <= '0;
            o_pixel <= 1'b0;
        end else begin
            if (do_commit) begin
                for (int k = 0; k < NUM_BARS; k++)
                    if (pending[k]) active_y[k] <= shadow_y[k];
                pending <= '0;
            end
            if (do_write) begin
                for (int k = 0; k < NUM_BARS; k++)
                    if (4'(k) == idx) begin
                        shadow_y[k] <= y_clamp;
                        pending[k]  <= 1'b1;
                    end
            end
            result  <= state == EXEC ? res_c : 32'h0;
            o_pixel <= i_active && hit;
        end
    end
endmodule

// File: tb/tb_bar_render_engine.sv
// tb_bar_render_engine: scoreboard bench for bar_render_engine against a bar-position reference model
module tb_bar_render_engine;
    localparam int NB = 2, BW = 10, BH = 80, XF = 15, XS = 270, SH = 600;
    localparam int YMAX = SH - BH, YINIT = (SH - BH) / 2;
    typedef struct {logic [31:0] res; int t;} cexp_t;
    typedef struct {int x; int y; bit a; bit p;} pexp_t;
    logic        i_clk = 0, i_rst = 1, i_clk_en = 0, i_start = 0, i_active = 0, i_frame = 0;
    logic [31:0] i_dataa = 0;
    logic [9:0]  i_x = 0, i_y = 0;
    logic        o_done, o_pixel;
    logic [31:0] o_result;
    int errors = 0, checks = 0, cyc = 0;
    int ac[NB], sh[NB];
    bit pd[NB];
    cexp_t cq[$];
    pexp_t pq[$];
    bit pix_drive = 0, pxv_d = 0;
    cexp_t me;
    pexp_t mp;

    bar_render_engine dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_clk_en(i_clk_en), .i_start(i_start), .i_dataa(i_dataa),
        .o_done(o_done), .o_result(o_result), .i_x(i_x), .i_y(i_y), .i_active(i_active),
        .i_frame(i_frame), .o_pixel(o_pixel)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) begin
        cyc   <= cyc + 1;
        pxv_d <= pix_drive;
    end

    function automatic void m_reset();
        for (int k = 0; k < NB; k++) begin
            ac[k] = YINIT;
            sh[k] = YINIT;
            pd[k] = 0;
        end
    endfunction

    function automatic void m_frame();
        for (int k = 0; k < NB; k++) begin
            if (pd[k]) ac[k] = sh[k];
            pd[k] = 0;
        end
    endfunction

    function automatic logic [31:0] m_cmd(input int op, input int idx, input int y);
        logic [9:0] v;
        if (idx >= NB) return 32'hFFFF_FFFF;
        if (op == 0) begin
            sh[idx] = y > YMAX ? YMAX : y;
            pd[idx] = 1;
        end
        if (op == 1) m_frame();
`ifdef BAR_READBACK_EN
        if (op == 2) begin
            v = 10'(ac[idx]);
            return {22'b0, v};
        end
        if (op == 3) begin
            v = 10'(sh[idx]);
            return {pd[idx], 21'b0, v};
        end
`endif
        v = 0;
        return {22'b0, v};
    endfunction

    function automatic bit m_pix(input int x, input int y, input bit a);
        if (!a) return 0;
        for (int k = 0; k < NB; k++)
            if (x >= XF + k * XS && x < XF + k * XS + BW && y >= ac[k] && y < ac[k] + BH) return 1;
        return 0;
    endfunction

    always @(negedge i_clk) begin
        if (o_done) begin
            checks++;
            if (cq.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: o_done=1 with no command outstanding (cycle %0d)", cyc);
            end else begin
                me = cq.pop_front();
                if (o_result !== me.res) begin
                    errors++;
                    $display("FAIL result: got %h expected %h", o_result, me.res);
                end
                checks++;
                if (cyc != me.t + 2) begin
                    errors++;
                    $display("FAIL done_latency: got %0d cycles expected 2", cyc - me.t);
                end
            end
        end
        if (pxv_d) begin
            checks++;
            if (pq.size() == 0) begin
                errors++;
                $display("FAIL pixel_queue: no expected pixel queued");
            end else begin
                mp = pq.pop_front();
                if (o_pixel !== mp.p) begin
                    errors++;
                    $display("FAIL pixel x=%0d y=%0d act=%0b: got %b expected %b", mp.x, mp.y, mp.a, o_pixel, mp.p);
                end
            end
        end
    end

    task automatic px(input int x, input int y, input bit a);
        pexp_t e;
        if (x < 0 || x > 1023 || y < 0 || y > 1023) return;
        i_x = 10'(x);
        i_y = 10'(y);
        i_active = a;
        pix_drive = 1;
        e.x = x; e.y = y; e.a = a; e.p = m_pix(x, y, a);
        pq.push_back(e);
        @(negedge i_clk);
    endtask

    task automatic sweep();
        for (int k = 0; k < NB; k++) begin
            for (int dx = 0; dx < 4; dx++)
                for (int dy = 0; dy < 4; dy++)
                    px(XF + k * XS + (dx == 0 ? -1 : dx == 1 ? 0 : dx == 2 ? BW - 1 : BW),
                       ac[k] + (dy == 0 ? -1 : dy == 1 ? 0 : dy == 2 ? BH - 1 : BH), 1);
            px(XF + k * XS + 3, ac[k] + 5, 0);
        end
        for (int i = 0; i < 12; i++) px(int'($urandom % 800), int'($urandom % 600), ($urandom % 4) != 0);
        pix_drive = 0;
        @(negedge i_clk);
    endtask

    task automatic cmd(input int op, input int idx, input int y, input bit fr);
        cexp_t e;
        logic [1:0] o2;
        logic [3:0] i4;
        logic [9:0] y10;
        o2 = 2'(op); i4 = 4'(idx); y10 = 10'(y);
        i_dataa = {o2, 14'b0, i4, 2'b0, y10};
        i_start = 1;
        i_clk_en = 1;
        if (fr) m_frame();
        e.res = m_cmd(op, idx, y);
        e.t = cyc;
        cq.push_back(e);
        @(negedge i_clk);
        i_start = 0;
        i_frame = fr;
        @(negedge i_clk);
        i_frame = 0;
        repeat (2) @(negedge i_clk);
    endtask

    task automatic frame();
        i_frame = 1;
        m_frame();
        @(negedge i_clk);
        i_frame = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    initial begin
        cexp_t e;
        m_reset();
        repeat (3) @(negedge i_clk);
        chk("rst_done", {31'b0, o_done}, 0);
        chk("rst_result", o_result, 0);
        chk("rst_pixel", {31'b0, o_pixel}, 0);
        i_rst = 0;
        @(negedge i_clk);
        sweep();
        cmd(0, 0, 100, 0);
        sweep();
        frame();
        sweep();
        cmd(0, 1, 1000, 0);
        cmd(1, 0, 0, 0);
        sweep();
        cmd(0, 5, 7, 0);
        sweep();
        // start held across EXEC and DONE must yield a single completion
        i_dataa = {2'b00, 14'b0, 4'd0, 2'b0, 10'd200};
        i_start = 1;
        i_clk_en = 1;
        e.res = m_cmd(0, 0, 200);
        e.t = cyc;
        cq.push_back(e);
        repeat (3) @(negedge i_clk);
        i_start = 0;
        repeat (3) @(negedge i_clk);
        // start with clock enable low is ignored
        i_start = 1;
        i_clk_en = 0;
        @(negedge i_clk);
        i_start = 0;
        i_clk_en = 1;
        repeat (4) @(negedge i_clk);
        frame();
        sweep();
        cmd(0, 1, 40, 0);
        cmd(0, 0, 300, 1);
        sweep();
        cmd(1, 0, 0, 1);
        sweep();
        // reset while the command is in EXEC aborts it
        i_dataa = {2'b00, 14'b0, 4'd0, 2'b0, 10'd77};
        i_start = 1;
        i_clk_en = 1;
        @(negedge i_clk);
        i_start = 0;
        i_rst = 1;
        @(negedge i_clk);
        i_rst = 0;
        m_reset();
        chk("abort_done", {31'b0, o_done}, 0);
        repeat (3) @(negedge i_clk);
        frame();
        sweep();
`ifdef BAR_READBACK_EN
        cmd(0, 0, 50, 0);
        cmd(3, 0, 0, 0);
        cmd(2, 0, 0, 0);
`endif
        for (int i = 0; i < 60; i++) begin
            case ($urandom % 6)
                0: cmd(0, int'($urandom % 4), int'($urandom % 1024), 0);
                1: cmd(1, int'($urandom % 3), 0, 0);
                2: frame();
                3: cmd(2 + int'($urandom % 2), int'($urandom % 3), 0, 0);
                4: cmd(0, int'($urandom % 3), int'($urandom % 1024), 1);
                default: cmd(0, int'($urandom % 2), int'($urandom % 600), 0);
            endcase
            if (i % 10 == 9) sweep();
        end
        sweep();
        for (int i = 0; i < 20 && (cq.size() != 0 || pq.size() != 0); i++) @(negedge i_clk);
        checks++;
        if (cq.size() != 0 || pq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d commands and %0d pixels still outstanding, expected 0", cq.size(), pq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
